// File: rtl/nlfsr_seed_ctrl.sv
// Seed sequencer for one NLFSR stage: serialises a captured seed onto d1 (LSB first),
// runs the init warm-up, then flags keystream valid and raises periodic reseed requests.
module nlfsr_seed_ctrl #(
    parameter int SEED_W          = 17,
    parameter int INIT_CYCLES     = 68,
    parameter int RESEED_INTERVAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic              abort,
    output logic              load,
    output logic              d1,
    output logic              init,
    output logic              ks_valid,
    output logic              reseed_req,
    output logic              busy
);
    localparam int MAX_SI  = (SEED_W > INIT_CYCLES) ? SEED_W : INIT_CYCLES;
    localparam int MAX_ALL = (MAX_SI > RESEED_INTERVAL) ? MAX_SI : RESEED_INTERVAL;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(SEED_W - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESEED_MAX = CNT_W'(RESEED_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_INIT, S_RUN} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  phase_cnt_reg, phase_cnt_next;
    logic [CNT_W-1:0]  ks_cnt_reg, ks_cnt_next;
    logic [SEED_W-1:0] shadow_reg, shadow_next;
    logic              seed_ready_reg, seed_ready_next;
    logic              load_reg, load_next;
    logic              d1_reg, d1_next;
    logic              init_reg, init_next;
    logic              ks_valid_reg, ks_valid_next;
    logic              reseed_req_reg, reseed_req_next;
    logic              busy_reg, busy_next;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            phase_cnt_reg  <= '0;
            ks_cnt_reg     <= '0;
            shadow_reg     <= '0;
            seed_ready_reg <= 1'b0;
            load_reg       <= 1'b0;
            d1_reg         <= 1'b0;
            init_reg       <= 1'b0;
            ks_valid_reg   <= 1'b0;
            reseed_req_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_cnt_reg  <= phase_cnt_next;
            ks_cnt_reg     <= ks_cnt_next;
            shadow_reg     <= shadow_next;
            seed_ready_reg <= seed_ready_next;
            load_reg       <= load_next;
            d1_reg         <= d1_next;
            init_reg       <= init_next;
            ks_valid_reg   <= ks_valid_next;
            reseed_req_reg <= reseed_req_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_cnt_next  = phase_cnt_reg;
        ks_cnt_next     = ks_cnt_reg;
        shadow_next     = shadow_reg;
        d1_next         = 1'b0;
        reseed_req_next = reseed_req_reg;
        accept          = seed_valid & seed_ready_reg & ~abort;

        if (abort) begin
            state_next      = S_IDLE;
            phase_cnt_next  = '0;
            ks_cnt_next     = '0;
            shadow_next     = '0;
            reseed_req_next = 1'b0;
        end else if (accept) begin
            // Bit 0 goes out on the first LOAD cycle; the shadow keeps the rest.
            state_next      = S_LOAD;
            phase_cnt_next  = '0;
            ks_cnt_next     = '0;
            shadow_next     = seed >> 1;
            d1_next         = seed[0];
            reseed_req_next = 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (phase_cnt_reg == LOAD_LAST) begin
                        state_next     = S_INIT;
                        phase_cnt_next = '0;
                    end else begin
                        phase_cnt_next = phase_cnt_reg + CNT_ONE;
                        d1_next        = shadow_reg[0];
                        shadow_next    = shadow_reg >> 1;
                    end
                end
                S_INIT: begin
                    if (phase_cnt_reg == INIT_LAST) begin
                        state_next     = S_RUN;
                        phase_cnt_next = '0;
                        ks_cnt_next    = '0;
                    end else begin
                        phase_cnt_next = phase_cnt_reg + CNT_ONE;
                    end
                end
                S_RUN: begin
                    // Saturating RUN-cycle count; the request is sticky until the next accept.
                    if (RESEED_INTERVAL != 0) begin
                        ks_cnt_next = (ks_cnt_reg == RESEED_MAX) ? ks_cnt_reg : ks_cnt_reg + CNT_ONE;
                        if (ks_cnt_next == RESEED_MAX) begin
                            reseed_req_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        load_next       = (state_next == S_LOAD);
        init_next       = (state_next == S_INIT);
        ks_valid_next   = (state_next == S_RUN);
        busy_next       = (state_next == S_LOAD) || (state_next == S_INIT);
        seed_ready_next = (state_next == S_IDLE) || (state_next == S_RUN);
    end

    assign seed_ready = seed_ready_reg;
    assign load       = load_reg;
    assign d1         = d1_reg;
    assign init       = init_reg;
    assign ks_valid   = ks_valid_reg;
    assign reseed_req = reseed_req_reg;
    assign busy       = busy_reg;

endmodule
